// File: rtl/fifo_rr_merge.sv
// Round-robin merge of two 1-cycle-latency FIFOs into one registered stream,
// with a per-port burst limit, downstream pause and per-port delivered counters.
module fifo_rr_merge #(
    parameter int DATA_WIDTH = 10,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty1,
    input  logic                  fifo_empty2,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic                  next_pause,
    output logic                  pop1,
    output logic                  pop2,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  src_out,
    output logic [CNT_WIDTH-1:0]  cnt1,
    output logic [CNT_WIDTH-1:0]  cnt2
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, SERVE1, SERVE2} state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic          last_served;
    logic          rd_valid;
    logic          rd_src;
    logic          any_pop;
    logic          same_port;

    always_comb begin
        pop1 = 1'b0;
        pop2 = 1'b0;
        if (!reset && !next_pause) begin
            if (!fifo_empty1 && fifo_empty2) begin
                pop1 = 1'b1;
            end else if (fifo_empty1 && !fifo_empty2) begin
                pop2 = 1'b1;
            end else if (!fifo_empty1 && !fifo_empty2) begin
                case (state)
                    SERVE1: begin
                        pop1 = (burst_cnt < BMAX);
                        pop2 = !(burst_cnt < BMAX);
                    end
                    SERVE2: begin
                        pop2 = (burst_cnt < BMAX);
                        pop1 = !(burst_cnt < BMAX);
                    end
                    default: begin
                        pop1 = last_served;
                        pop2 = !last_served;
                    end
                endcase
            end
        end
    end

    assign any_pop   = pop1 | pop2;
    assign same_port = (pop1 && state == SERVE1) || (pop2 && state == SERVE2);

    // rd_valid/rd_src track the pop whose read data arrives this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_served <= 1'b1;
            rd_valid    <= 1'b0;
            rd_src      <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            src_out     <= 1'b0;
            cnt1        <= '0;
            cnt2        <= '0;
        end else begin
            if (any_pop) begin
                state       <= pop1 ? SERVE1 : SERVE2;
                last_served <= pop2;
                if (!same_port)
                    burst_cnt <= BW'(1);
                else if (burst_cnt != BMAX)
                    burst_cnt <= burst_cnt + BW'(1);
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
            rd_valid  <= any_pop;
            rd_src    <= pop2;
            valid_out <= rd_valid;
            if (rd_valid) begin
                src_out  <= rd_src;
                data_out <= rd_src ? data_in2 : data_in1;
                if (rd_src)
                    cnt2 <= cnt2 + CNT_WIDTH'(1);
                else
                    cnt1 <= cnt1 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Bench for fifo_rr_merge: directed table, corner sequences and a random run
// against a queue-based reference model of two FIFOs and the merge rules.
module tb_fifo_rr_merge;

    localparam int DW = 10;
    localparam int MB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty1;
    logic          fifo_empty2;
    logic [DW-1:0] data_in1;
    logic [DW-1:0] data_in2;
    logic          next_pause;
    logic          pop1;
    logic          pop2;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          src_out;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;

    fifo_rr_merge #(.DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2),
        .data_in1(data_in1), .data_in2(data_in2),
        .next_pause(next_pause),
        .pop1(pop1), .pop2(pop2),
        .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
        .cnt1(cnt1), .cnt2(cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];

    // reference model state
    int            m_prev = 0;
    int            m_run = 0;
    int            m_last = 2;
    logic          pend_v = 1'b0;
    logic          pend_s = 1'b0;
    logic [DW-1:0] pend_d = '0;
    logic          m_valid = 1'b0;
    logic          m_src = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [CW-1:0] m_cnt1 = '0;
    logic [CW-1:0] m_cnt2 = '0;

    logic          s_valid;
    logic [CW-1:0] s_cnt1;
    logic [CW-1:0] s_cnt2;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decide(input logic r, input logic p,
                                  input int n1, input int n2);
        if (r || p || (n1 == 0 && n2 == 0)) return 0;
        if (n2 == 0) return 1;
        if (n1 == 0) return 2;
        if (m_prev != 0) return (m_run < MB) ? m_prev : 3 - m_prev;
        return 3 - m_last;
    endfunction

    task automatic step(input logic r, input logic p,
                        output logic a1, output logic a2);
        int mp;
        reset       = r;
        next_pause  = p;
        fifo_empty1 = (q1.size() == 0);
        fifo_empty2 = (q2.size() == 0);
        @(negedge clk);
        mp = decide(r, p, q1.size(), q2.size());
        chk("pop1", pop1, mp == 1);
        chk("pop2", pop2, mp == 2);
        chk("valid_out", valid_out, m_valid);
        chk("data_out", data_out, m_data);
        if (m_valid) chk("src_out", src_out, m_src);
        chk("cnt1", cnt1, m_cnt1);
        chk("cnt2", cnt2, m_cnt2);
        a1 = pop1;
        a2 = pop2;
        s_valid = valid_out;
        s_cnt1 = cnt1;
        s_cnt2 = cnt2;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = '0; m_src = 0;
            m_cnt1 = '0; m_cnt2 = '0; pend_v = 0;
            m_prev = 0; m_run = 0; m_last = 2;
        end else begin
            m_valid = pend_v;
            if (pend_v) begin
                m_data = pend_d;
                m_src  = pend_s;
                if (pend_s) m_cnt2++; else m_cnt1++;
            end
            pend_v = (mp != 0);
            pend_s = (mp == 2);
            if (mp != 0) begin
                m_run  = (mp == m_prev) ? m_run + 1 : 1;
                m_prev = mp;
                m_last = mp;
            end else begin
                m_prev = 0;
                m_run  = 0;
            end
        end
        #1;
        if (mp == 1) begin
            data_in1 = q1.pop_front();
            pend_d   = data_in1;
        end else begin
            data_in1 = DW'($urandom);
        end
        if (mp == 2) begin
            data_in2 = q2.pop_front();
            pend_d   = data_in2;
        end else begin
            data_in2 = DW'($urandom);
        end
    endtask

    task automatic restart();
        logic a1, a2;
        q1.delete();
        q2.delete();
        step(1, 0, a1, a2);
        step(1, 0, a1, a2);
    endtask

    typedef struct {
        logic rst;
        logic pause;
        logic p1;
        logic p2;
        logic v;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic a1, a2;
        tbl[0]  = '{1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 1};
        tbl[5]  = '{0, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 1, 0, 1};
        tbl[12] = '{0, 0, 1, 0, 1};
        tbl[13] = '{0, 0, 1, 0, 1};
        tbl[14] = '{0, 1, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 1, 1};
        tbl[16] = '{0, 0, 0, 1, 0};

        reset = 1; next_pause = 0;
        fifo_empty1 = 1; fifo_empty2 = 1;
        data_in1 = '0; data_in2 = '0;
        @(posedge clk);
        #1;

        // reset with both FIFOs full, then round-robin bursts and a pause
        for (int i = 0; i < 10; i++) begin
            q1.push_back(DW'(10'h100 + i));
            q2.push_back(DW'(10'h200 + i));
        end
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].pause, a1, a2);
            chk($sformatf("tbl%0d_pop1", i), a1, tbl[i].p1);
            chk($sformatf("tbl%0d_pop2", i), a2, tbl[i].p2);
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].v);
        end

        // single-port stream of three words
        restart();
        q1.push_back(10'h011);
        q1.push_back(10'h022);
        q1.push_back(10'h033);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, a1, a2);
            chk("solo_pop1", a1, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(0, 0, a1, a2);
        chk("solo_cnt1", s_cnt1, 16'd3);

        // pause right after a pop: word still delivered, resume same port
        restart();
        for (int i = 0; i < 3; i++) q1.push_back(DW'(10'h0a0 + i));
        step(0, 0, a1, a2);
        chk("pz_pop", a1, 1'b1);
        step(0, 1, a1, a2);
        chk("pz_hold1", a1 | a2, 1'b0);
        step(0, 1, a1, a2);
        chk("pz_hold2", a1 | a2, 1'b0);
        chk("pz_deliver", s_valid, 1'b1);
        step(0, 0, a1, a2);
        chk("pz_resume", a1, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, a1, a2);

        // FIFO2 drains mid-burst: switch back to FIFO1 at once
        restart();
        for (int i = 0; i < 6; i++) q1.push_back(DW'(10'h300 + i));
        q2.push_back(10'h3f0);
        q2.push_back(10'h3f1);
        for (int i = 0; i < 4; i++) step(0, 0, a1, a2);
        step(0, 0, a1, a2);
        chk("drain_p2a", a2, 1'b1);
        step(0, 0, a1, a2);
        chk("drain_p2b", a2, 1'b1);
        step(0, 0, a1, a2);
        chk("drain_sw", a1, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, a1, a2);

        // reset one cycle after a pop2: word dropped
        restart();
        q2.push_back(10'h155);
        step(0, 0, a1, a2);
        chk("rs_pop2", a2, 1'b1);
        step(1, 0, a1, a2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, a1, a2);
            chk("rs_novalid", s_valid, 1'b0);
        end
        chk("rs_cnt2", s_cnt2, 16'd0);

        // random traffic against the model
        restart();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 45) q1.push_back(DW'($urandom));
            if ($urandom_range(99) < 45) q2.push_back(DW'($urandom));
            step($urandom_range(99) < 1, $urandom_range(99) < 20, a1, a2);
            chk("rnd_excl", a1 & a2, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(0, 1, a1, a2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
